// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction-memory req/ack side, decode valid/ready side and redirect input.
// master = fetch unit, slave = memory/decode/branch environment.
interface instr_fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) ();
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         opCode;
    logic [ADDR_W-1:0]  instr_pc;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opCode, instr_pc,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opCode, instr_pc,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem req/ack into a DEPTH-entry prefetch FIFO; ack->instr_valid 1 cycle.
// Backpressure: fetching pauses while the FIFO is full; redirect flushes. FETCH_CNT_EN adds fetch_cnt.
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
`ifdef FETCH_CNT_EN
    ,output logic [15:0]  fetch_cnt
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {FETCH, STALL, DISCARD} state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0]  pc_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_d [DEPTH];
    logic [INSTR_W-1:0] dat_mem_q [DEPTH];
    logic [INSTR_W-1:0] dat_mem_d [DEPTH];
    logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
    logic [INSTR_W-1:0] hold_dat_q, hold_dat_d;

    logic vld, ack_hit, pop, push;

    assign vld     = (cnt_q != '0);
    assign ack_hit = req_q & bus.imem_ack;
    assign pop     = vld & bus.instr_ready;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        pc_mem_d   = pc_mem_q;
        dat_mem_d  = dat_mem_q;
        hold_pc_d  = hold_pc_q;
        hold_dat_d = hold_dat_q;
        push       = 1'b0;

        // Remember the presented head so outputs stay stable once the FIFO drains.
        if (vld) begin
            hold_pc_d  = pc_mem_q[rd_q];
            hold_dat_d = dat_mem_q[rd_q];
        end

        if (bus.redirect) begin
            cnt_d  = '0;
            rd_d   = '0;
            wr_d   = '0;
            pend_d = bus.redirect_pc;
            req_d  = 1'b1;
            if (req_q && !bus.imem_ack) begin
                // Memory still owes us a word for the old path; keep addr stable until it arrives.
                state_d = DISCARD;
            end else begin
                state_d = FETCH;
                addr_d  = bus.redirect_pc;
            end
        end else if (state_q == DISCARD) begin
            if (ack_hit) begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = pend_q;
            end
        end else begin
            push = ack_hit;
            if (push) begin
                pc_mem_d[wr_q]  = addr_q;
                dat_mem_d[wr_q] = bus.imem_rdata;
                wr_d            = (wr_q == LAST_P) ? '0 : wr_q + PTR_W'(1);
                addr_d          = addr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_d = (rd_q == LAST_P) ? '0 : rd_q + PTR_W'(1);
            end
            if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
            else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
            req_d   = (req_q && !bus.imem_ack) ? 1'b1 : (cnt_d < DEPTH_C);
            state_d = req_d ? FETCH : STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            pend_q     <= RESET_PC;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            hold_pc_q  <= '0;
            hold_dat_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                dat_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            hold_pc_q  <= hold_pc_d;
            hold_dat_q <= hold_dat_d;
            pc_mem_q   <= pc_mem_d;
            dat_mem_q  <= dat_mem_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = vld;
    assign bus.instr       = vld ? dat_mem_q[rd_q] : hold_dat_q;
    assign bus.instr_pc    = vld ? pc_mem_q[rd_q]  : hold_pc_q;
    assign bus.opCode      = bus.instr[INSTR_W-1 -: 4];

`ifdef FETCH_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    // Counts decode handshakes; words flushed before acceptance never handshake.
    always_comb begin
        fcnt_d = fcnt_q;
        if (pop && (fcnt_q != 16'hFFFF)) fcnt_d = fcnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fcnt_q <= '0;
        else        fcnt_q <= fcnt_d;
    end

    assign fetch_cnt = fcnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: in-order fetch, stall, redirect/discard, address wrap, async reset.
module tb_instr_fetch;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    instr_fetch_if #(.ADDR_W(16), .INSTR_W(16)) bus ();
    instr_fetch_if #(.ADDR_W(16), .INSTR_W(16)) wbus ();

`ifdef FETCH_CNT_EN
    logic [15:0] fcnt, wfcnt;
`endif

    instr_fetch #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_CNT_EN
        ,.fetch_cnt (fcnt)
`endif
    );

    instr_fetch #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE), .DEPTH(2)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus)
`ifdef FETCH_CNT_EN
        ,.fetch_cnt (wfcnt)
`endif
    );

    function automatic logic [15:0] data_of(input logic [15:0] a);
        return {a[3:0] ^ 4'h9, 4'h0, a[7:0]};
    endfunction

    // Wrap instance: memory acks every request in the same cycle, decode always ready.
    assign wbus.imem_ack    = wbus.imem_req;
    assign wbus.imem_rdata  = data_of(wbus.imem_addr);
    assign wbus.instr_ready = 1'b1;
    assign wbus.redirect    = 1'b0;
    assign wbus.redirect_pc = 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fetch_one(input int dly, output logic [15:0] a);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", 32'(bus.imem_req), 32'd1);
        a = bus.imem_addr;
        repeat (dly) @(negedge clk);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data_of(a);
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
    endtask

    logic [15:0] t1_dat [4] = '{16'h9000, 16'h8001, 16'hB002, 16'hA003};
    logic [3:0]  t1_op  [4] = '{4'h9, 4'h8, 4'hB, 4'hA};
    logic [15:0] t5_adr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    initial begin
        logic [15:0] a;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0;
        #1 rst_n = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_req",   32'(bus.imem_req),    32'd0);
        check("rst_addr",  32'(bus.imem_addr),   32'h0);
        check("rst_vld",   32'(bus.instr_valid), 32'd0);
        check("rst_instr", 32'(bus.instr),       32'h0);
        check("rst_op",    32'(bus.opCode),      32'h0);
        check("rst_pc",    32'(bus.instr_pc),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rel_req_low", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        check("rel_req_high", 32'(bus.imem_req),  32'd1);
        check("rel_addr",     32'(bus.imem_addr), 32'h0);

        // 1: in-order fetch with 1-cycle ack delay, decode always ready
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fetch_one(1, a);
            check("t1_addr",  32'(a),               32'(k));
            check("t1_vld",   32'(bus.instr_valid), 32'd1);
            check("t1_pc",    32'(bus.instr_pc),    32'(k));
            check("t1_instr", 32'(bus.instr),       32'(t1_dat[k]));
            check("t1_op",    32'(bus.opCode),      32'(t1_op[k]));
        end
`ifdef FETCH_CNT_EN
        check("t1_fcnt", 32'(fcnt), 32'd3);
`endif

        // 2: decode stalled, FIFO fills to DEPTH, one pop restarts fetch
        do_reset();
        fetch_one(0, a);
        check("t2_addr0", 32'(a), 32'h0);
        fetch_one(0, a);
        check("t2_addr1", 32'(a), 32'h1);
        check("t2_stall_req", 32'(bus.imem_req),    32'd0);
        check("t2_vld",       32'(bus.instr_valid), 32'd1);
        check("t2_head",      32'(bus.instr_pc),    32'h0);
        @(negedge clk);
        check("t2_stall_hold", 32'(bus.imem_req), 32'd0);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        check("t2_rereq",  32'(bus.imem_req),  32'd1);
        check("t2_readdr", 32'(bus.imem_addr), 32'h2);
        check("t2_head1",  32'(bus.instr_pc),  32'h1);
        fetch_one(0, a);
        check("t2_addr2", 32'(a), 32'h2);
        check("t2_full_req", 32'(bus.imem_req), 32'd0);
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0100;
        @(negedge clk);
        bus.redirect = 1'b0;
        check("t2_flush_vld", 32'(bus.instr_valid), 32'd0);
        check("t2_redir_req", 32'(bus.imem_req),    32'd1);
        check("t2_redir_adr", 32'(bus.imem_addr),   32'h0100);

        // 3: redirect while a request is outstanding -> that word is discarded
        do_reset();
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) fetch_one(0, a);
        check("t3_addr5", 32'(bus.imem_addr), 32'h5);
        @(negedge clk);
        check("t3_drained", 32'(bus.instr_valid), 32'd0);
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
        @(negedge clk);
        bus.redirect = 1'b0;
        check("t3_hold_req", 32'(bus.imem_req),    32'd1);
        check("t3_hold_adr", 32'(bus.imem_addr),   32'h5);
        check("t3_vld0",     32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        check("t3_vld1", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        bus.imem_ack = 1'b1; bus.imem_rdata = data_of(16'h5);
        @(negedge clk);
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        check("t3_drop_vld", 32'(bus.instr_valid), 32'd0);
        check("t3_new_req",  32'(bus.imem_req),    32'd1);
        check("t3_new_adr",  32'(bus.imem_addr),   32'h0040);
        fetch_one(0, a);
        check("t3_vld",   32'(bus.instr_valid), 32'd1);
        check("t3_pc",    32'(bus.instr_pc),    32'h0040);
        check("t3_instr", 32'(bus.instr),       32'h9040);

        // 4: redirect and ack in the same cycle
        do_reset();
        @(negedge clk);
        check("t4_req", 32'(bus.imem_req), 32'd1);
        bus.imem_ack = 1'b1; bus.imem_rdata = data_of(16'h0);
        bus.redirect = 1'b1; bus.redirect_pc = 16'h1234;
        @(negedge clk);
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.redirect = 1'b0;
        check("t4_vld",  32'(bus.instr_valid), 32'd0);
        check("t4_req1", 32'(bus.imem_req),    32'd1);
        check("t4_addr", 32'(bus.imem_addr),   32'h1234);
        @(negedge clk);
        check("t4_empty", 32'(bus.instr_valid), 32'd0);
        fetch_one(0, a);
        check("t4_vld2", 32'(bus.instr_valid), 32'd1);
        check("t4_pc",   32'(bus.instr_pc),    32'h1234);

        // 5: RESET_PC near the top of the address space wraps to zero
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("t5_req",  32'(wbus.imem_req),  32'd1);
            check("t5_addr", 32'(wbus.imem_addr), 32'(t5_adr[k]));
            if (k < 3) @(negedge clk);
        end
        check("t5_pc", 32'(wbus.instr_pc), 32'h0000);

        // 6: async reset mid-request with one word buffered
        do_reset();
        bus.instr_ready = 1'b1;
        fetch_one(0, a);
        fetch_one(0, a);
        bus.instr_ready = 1'b0;
        check("t6_vld", 32'(bus.instr_valid), 32'd1);
        check("t6_req", 32'(bus.imem_req),    32'd1);
`ifdef FETCH_CNT_EN
        check("t6_fcnt_pre", 32'(fcnt), 32'd1);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_vld",  32'(bus.instr_valid), 32'd0);
        check("t6_async_req",  32'(bus.imem_req),    32'd0);
        check("t6_async_addr", 32'(bus.imem_addr),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rel_req",  32'(bus.imem_req),    32'd1);
        check("t6_rel_addr", 32'(bus.imem_addr),   32'h0);
        check("t6_rel_vld",  32'(bus.instr_valid), 32'd0);
`ifdef FETCH_CNT_EN
        check("t6_fcnt", 32'(fcnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
